// File: rtl/txn_mem_slave.sv
// txn_mem_slave: single-port word memory target for the fabric txn bus.
// A request is latched while idle and completes after a programmable number of
// wait cycles. Reads return the word, or zero with an error flag for bad
// addresses. Writes honour byte strobes. Read and write completions are
// counted with saturating counters.
module txn_mem_slave #(
    parameter int              DW        = 32,
    parameter int              AW        = 32,
    parameter int              DEPTH     = 128,
    parameter logic [AW-1:0]   BASE      = 'h40000000,
    parameter int              RD_LAT    = 4,
    parameter int              WR_LAT    = 4,
    parameter string           INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              txn_req,
    input  logic              txn_wr,
    input  logic [AW-1:0]     txn_addr,
    input  logic [DW-1:0]     txn_wdata,
    input  logic [DW/8-1:0]   txn_wstrb,
    output logic [DW-1:0]     txn_rdata,
    output logic              txn_rdy,
    output logic              txn_err,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] ALIGN_MASK = AW'((64'd1 << OB) - 64'd1);
    localparam logic [AW-1:0] DEPTH_W    = AW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_t;

    logic [DW-1:0]   mem [DEPTH];

    state_t          state;
    logic [4:0]      cnt;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [NB-1:0]   lat_wstrb;

    logic [AW-1:0]   off;
    logic [AW-1:0]   word_idx;
    logic            addr_ok;
    logic [IW-1:0]   mem_idx;
    logic            do_write;

    // Decode the latched address into the window; subtraction is unsigned so
    // addresses below BASE are rejected explicitly rather than wrapping in.
    always_comb begin
        off      = lat_addr - BASE;
        word_idx = off >> OB;
        addr_ok  = (lat_addr >= BASE) && ((off & ALIGN_MASK) == '0) && (word_idx < DEPTH_W);
        mem_idx  = word_idx[IW-1:0];
        do_write = arst_n && (state == WR_WAIT) && (cnt == 5'd0) && addr_ok;
    end

    // Array update at the completion edge of a valid write; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (lat_wstrb[i]) begin
                    mem[mem_idx][i*8 +: 8] <= lat_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Transaction FSM: accept while idle, count down the wait, then complete.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            txn_rdy   <= 1'b1;
            txn_rdata <= '0;
            txn_err   <= 1'b0;
            rd_cnt    <= 16'd0;
            wr_cnt    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (txn_req) begin
                        lat_addr  <= txn_addr;
                        lat_wdata <= txn_wdata;
                        lat_wstrb <= txn_wstrb;
                        txn_rdy   <= 1'b0;
                        txn_err   <= 1'b0;
                        if (txn_wr) begin
                            cnt   <= 5'(WR_LAT);
                            state <= WR_WAIT;
                        end else begin
                            cnt   <= 5'(RD_LAT);
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end else begin
                        txn_rdy <= 1'b1;
                        state   <= IDLE;
                        if (addr_ok) begin
                            txn_rdata <= mem[mem_idx];
                        end else begin
                            txn_rdata <= '0;
                            txn_err   <= 1'b1;
                        end
                        if (rd_cnt != 16'hFFFF) begin
                            rd_cnt <= rd_cnt + 16'd1;
                        end
                    end
                end
                WR_WAIT: begin
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end else begin
                        txn_rdy <= 1'b1;
                        state   <= IDLE;
                        if (!addr_ok) begin
                            txn_err <= 1'b1;
                        end
                        if (wr_cnt != 16'hFFFF) begin
                            wr_cnt <= wr_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txn_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_txn_mem_slave.sv
// Testbench for txn_mem_slave: one instance with 4-cycle latencies for the
// directed cases and one zero-latency instance for back-to-back traffic.
module tb_txn_mem_slave;

    logic clk = 1'b0;
    logic arst_n;

    always #5 clk = ~clk;

    logic        reqA, wrA, rdyA, errA;
    logic [31:0] addrA, wdataA, rdataA;
    logic [3:0]  strbA;
    logic [15:0] rcA, wcA;

    logic        reqB, wrB, rdyB, errB;
    logic [31:0] addrB, wdataB, rdataB;
    logic [3:0]  strbB;
    logic [15:0] rcB, wcB;

    txn_mem_slave #(.RD_LAT(4), .WR_LAT(4)) dut (
        .clk(clk), .arst_n(arst_n), .txn_req(reqA), .txn_wr(wrA), .txn_addr(addrA),
        .txn_wdata(wdataA), .txn_wstrb(strbA), .txn_rdata(rdataA), .txn_rdy(rdyA),
        .txn_err(errA), .rd_cnt(rcA), .wr_cnt(wcA)
    );

    txn_mem_slave #(.RD_LAT(0), .WR_LAT(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .txn_req(reqB), .txn_wr(wrB), .txn_addr(addrB),
        .txn_wdata(wdataB), .txn_wstrb(strbB), .txn_rdata(rdataB), .txn_rdy(rdyB),
        .txn_err(errB), .rd_cnt(rcB), .wr_cnt(wcB)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] rdc;
        logic [15:0] wrc;
    } exp_t;

    exp_t        sbA[$];
    exp_t        sbB[$];
    logic [31:0] memA [128];
    logic [31:0] memB [128];
    logic [31:0] lastRd [2];
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
    int          checks = 0;
    int          errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit decodeAddr(input logic [31:0] addr, output int idx);
        logic [31:0] off;
        off = addr - 32'h40000000;
        idx = int'(off >> 2);
        return (addr >= 32'h40000000) && (off[1:0] == 2'b00) && ((off >> 2) < 32'd128);
    endfunction

    // Reference model: updates the model memory and pushes the expected completion.
    task automatic modelTxn(input bit sel, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        int          idx;
        bit          ok;
        logic [31:0] w;
        exp_t        e;
        ok = decodeAddr(addr, idx);
        if (wr) begin
            if (ok) begin
                w = sel ? memB[idx] : memA[idx];
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) w[i*8 +: 8] = data[i*8 +: 8];
                end
                if (sel) memB[idx] = w;
                else     memA[idx] = w;
            end
            if (wrc[sel] != 16'hFFFF) wrc[sel] = wrc[sel] + 16'd1;
        end else begin
            lastRd[sel] = ok ? (sel ? memB[idx] : memA[idx]) : 32'h0;
            if (rdc[sel] != 16'hFFFF) rdc[sel] = rdc[sel] + 16'd1;
        end
        e.rdata = lastRd[sel];
        e.err   = !ok;
        e.rdc   = rdc[sel];
        e.wrc   = wrc[sel];
        if (sel) sbB.push_back(e);
        else     sbA.push_back(e);
    endtask

    // Pops the oldest expected completion for one instance and compares outputs.
    task automatic checkOutput(input bit sel, input string tag);
        exp_t e;
        int   n;
        n = sel ? sbB.size() : sbA.size();
        checkVal({tag, "/sb_nonempty"}, 32'(n != 0), 32'd1);
        if (n != 0) begin
            if (sel) begin
                e = sbB.pop_front();
                checkVal({tag, "/rdata"}, rdataB, e.rdata);
                checkVal({tag, "/err"}, 32'(errB), 32'(e.err));
                checkVal({tag, "/rd_cnt"}, 32'(rcB), 32'(e.rdc));
                checkVal({tag, "/wr_cnt"}, 32'(wcB), 32'(e.wrc));
            end else begin
                e = sbA.pop_front();
                checkVal({tag, "/rdata"}, rdataA, e.rdata);
                checkVal({tag, "/err"}, 32'(errA), 32'(e.err));
                checkVal({tag, "/rd_cnt"}, 32'(rcA), 32'(e.rdc));
                checkVal({tag, "/wr_cnt"}, 32'(wcA), 32'(e.wrc));
            end
        end
    endtask

    // Issues one transaction on the latency-4 instance and checks busy length and result.
    task automatic applyStimulus(input string tag, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        int guard;
        int low;
        guard = 0;
        @(negedge clk);
        while (!rdyA && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        reqA   = 1'b1;
        wrA    = wr;
        addrA  = addr;
        wdataA = data;
        strbA  = strb;
        modelTxn(1'b0, wr, addr, data, strb);
        @(posedge clk);
        @(negedge clk);
        reqA = 1'b0;
        low  = 0;
        while (!rdyA && low < 64) begin
            low++;
            @(negedge clk);
        end
        checkVal({tag, "/busy_cycles"}, 32'(low), 32'd5);
        checkOutput(1'b0, tag);
    endtask

    initial begin
        int guard;
        arst_n = 1'b0;
        reqA = 0; wrA = 0; addrA = 0; wdataA = 0; strbA = 0;
        reqB = 0; wrB = 0; addrB = 0; wdataB = 0; strbB = 0;
        for (int s = 0; s < 2; s++) begin
            lastRd[s] = 32'h0;
            rdc[s]    = 16'd0;
            wrc[s]    = 16'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkVal("reset/rdy", 32'(rdyA), 32'd1);
        checkVal("reset/rdata", rdataA, 32'h0);
        checkVal("reset/err", 32'(errA), 32'd0);
        checkVal("reset/rd_cnt", 32'(rcA), 32'd0);
        checkVal("reset/wr_cnt", 32'(wcA), 32'd0);
        checkVal("reset/rdy0", 32'(rdyB), 32'd1);

        $display("[TB] basic read of word 0");
        applyStimulus("preload_w0", 1'b1, 32'h40000000, 32'hDEADBEEF, 4'hF);
        applyStimulus("read_w0", 1'b0, 32'h40000000, 32'h0, 4'h0);

        $display("[TB] byte strobes");
        applyStimulus("clear_w4", 1'b1, 32'h40000010, 32'h0, 4'hF);
        applyStimulus("strb_w4", 1'b1, 32'h40000010, 32'h11223344, 4'b0101);
        applyStimulus("read_w4", 1'b0, 32'h40000010, 32'h0, 4'h0);
        applyStimulus("nostrb_w4", 1'b1, 32'h40000010, 32'hFFFFFFFF, 4'b0000);
        applyStimulus("reread_w4", 1'b0, 32'h40000010, 32'h0, 4'h0);

        $display("[TB] bad addresses");
        applyStimulus("rd_idx128", 1'b0, 32'h40000200, 32'h0, 4'h0);
        applyStimulus("rd_misalign", 1'b0, 32'h40000002, 32'h0, 4'h0);
        applyStimulus("rd_below", 1'b0, 32'h3FFFFFFC, 32'h0, 4'h0);
        applyStimulus("wr_idx129", 1'b1, 32'h40000204, 32'h55555555, 4'hF);
        applyStimulus("rd_last", 1'b0, 32'h400001FC, 32'h0, 4'h0);
        applyStimulus("wr_last", 1'b1, 32'h400001FC, 32'hCAFEF00D, 4'hF);
        applyStimulus("rd_last2", 1'b0, 32'h400001FC, 32'h0, 4'h0);

        $display("[TB] reset during a write");
        applyStimulus("old_w5", 1'b1, 32'h40000014, 32'hAABBCCDD, 4'hF);
        @(negedge clk);
        reqA = 1'b1; wrA = 1'b1; addrA = 32'h40000014; wdataA = 32'h12345678; strbA = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reqA = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            lastRd[s] = 32'h0;
            rdc[s]    = 16'd0;
            wrc[s]    = 16'd0;
        end
        checkVal("abort/rdy", 32'(rdyA), 32'd1);
        checkVal("abort/wr_cnt", 32'(wcA), 32'd0);
        checkVal("abort/rd_cnt", 32'(rcA), 32'd0);
        checkVal("abort/rdata", rdataA, 32'h0);
        applyStimulus("read_w5", 1'b0, 32'h40000014, 32'h0, 4'h0);

        $display("[TB] zero-latency back-to-back");
        guard = 0;
        @(negedge clk);
        while (!rdyB && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 20; i++) begin
            reqB   = 1'b1;
            wrB    = (i % 2 == 0);
            addrB  = 32'h40000000 + 32'((20 + i / 2) * 4);
            wdataB = $urandom;
            strbB  = 4'hF;
            modelTxn(1'b1, wrB, addrB, wdataB, strbB);
            @(posedge clk);
            @(negedge clk);
            checkVal($sformatf("b2b%0d/busy", i), 32'(rdyB), 32'd0);
            @(posedge clk);
            @(negedge clk);
            checkVal($sformatf("b2b%0d/done", i), 32'(rdyB), 32'd1);
            checkOutput(1'b1, $sformatf("b2b%0d", i));
        end
        reqB = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
